// File: rtl/sram_responder_if.sv
// sram_responder_if -- address/control side of an asynchronous-style SRAM bus.
//
// Carries the halfword address and the active-low strobes. The 16-bit data
// bus is bidirectional, so it stays a plain inout port on the responder.
//
// Signals:
//   SRAM_ADDRESS [17:0]  halfword address
//   SRAM_UB_N            upper byte lane enable [15:8], active-low
//   SRAM_LB_N            lower byte lane enable [7:0], active-low
//   SRAM_WE_N            write enable, active-low
//   SRAM_CE_N            chip enable, active-low
//   SRAM_OE_N            output enable, active-low
// Modports:
//   master  drives all signals (bus controller / testbench)
//   slave   samples all signals (sram_responder)
interface sram_responder_if;
  logic [17:0] SRAM_ADDRESS;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_WE_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  modport master (
    output SRAM_ADDRESS, SRAM_UB_N, SRAM_LB_N,
    output SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input SRAM_ADDRESS, SRAM_UB_N, SRAM_LB_N,
    input SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder -- behavioural SRAM device model with programmable read latency.
//
// Holds 2^DEPTH_LOG2 x 16-bit words indexed by the low address bits (upper
// bits alias). A write edge (CE_N=0, WE_N=0) updates the enabled byte lanes
// and always wins over a read in progress. A read request (CE_N=0, WE_N=1,
// OE_N=0) is captured, waits READ_LATENCY edges, then the data register is
// presented on SRAM_DATA while the request is held.
//
// Parameters:
//   DEPTH_LOG2    log2 of the number of storage words (default 10)
//   READ_LATENCY  edges from read sample to data on the bus, 1..8 (default 1)
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset (storage is not cleared)
//   ctrl         sram_responder_if.slave: address, lane enables, strobes
//   SRAM_DATA    bidirectional data bus, driven only while presenting a read
//   rdata_valid  high while read data is being driven
//   rd_count     saturating count of entries into the data-drive state
//   wr_count     saturating count of write edges
// Configuration:
//   SRAM_RESP_STATS_EN  defined -> rd_count/wr_count counters are built;
//                       undefined -> both outputs are tied to zero.
module sram_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   ctrl,
  inout  wire  [15:0]       SRAM_DATA,
  output logic              rdata_valid,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int        WORDS    = 2 ** DEPTH_LOG2;
  // Wait-state preload; only meaningful when READ_LATENCY >= 2.
  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE
  } state_t;

  logic [15:0] mem [WORDS];

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [15:0] q, q_n;
  logic [17:0] cap, cap_n;
  logic        start;
  logic        rd_enter;

  logic                  wr_hit;
  logic                  rd_req;
  logic                  addr_same;
  logic                  drive_en;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] cap_idx;

  assign wr_hit    = !ctrl.SRAM_CE_N && !ctrl.SRAM_WE_N;
  assign rd_req    = !ctrl.SRAM_CE_N &&  ctrl.SRAM_WE_N && !ctrl.SRAM_OE_N;
  assign addr_same = (ctrl.SRAM_ADDRESS == cap);
  assign idx       = ctrl.SRAM_ADDRESS[DEPTH_LOG2-1:0];
  assign cap_idx   = cap[DEPTH_LOG2-1:0];

  // Storage: no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      if (!ctrl.SRAM_UB_N) mem[idx][15:8] <= SRAM_DATA[15:8];
      if (!ctrl.SRAM_LB_N) mem[idx][7:0]  <= SRAM_DATA[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      cap   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      cap   <= cap_n;
    end
  end

  // A write edge forces IDLE regardless of read progress. "start" is shared
  // by IDLE and by an address change in RD_DRIVE so both launch reads alike.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    q_n      = q;
    cap_n    = cap;
    start    = 1'b0;
    rd_enter = 1'b0;

    if (wr_hit) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) start = 1'b1;
        end
        RD_WAIT: begin
          if (!rd_req || !addr_same) begin
            state_n = IDLE;
          end else if (cnt == '0) begin
            q_n      = mem[cap_idx];
            state_n  = RD_DRIVE;
            rd_enter = 1'b1;
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end
        RD_DRIVE: begin
          if (!rd_req)         state_n = IDLE;
          else if (!addr_same) start   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end

    if (start) begin
      cap_n = ctrl.SRAM_ADDRESS;
      if (READ_LATENCY == 1) begin
        q_n      = mem[idx];
        state_n  = RD_DRIVE;
        rd_enter = 1'b1;
      end else begin
        cnt_n   = LAT_INIT;
        state_n = RD_WAIT;
      end
    end
  end

  // Bus drive follows the live strobes so a write or OE_N release frees the
  // bus combinationally, without waiting for the state register.
  assign drive_en    = (state == RD_DRIVE) && rd_req;
  assign rdata_valid = drive_en;

  assign SRAM_DATA[15:8] = (drive_en && !ctrl.SRAM_UB_N) ? q[15:8] : 8'bz;
  assign SRAM_DATA[7:0]  = (drive_en && !ctrl.SRAM_LB_N) ? q[7:0]  : 8'bz;

`ifdef SRAM_RESP_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_enter && (rd_cnt != '1)) rd_cnt <= rd_cnt + 16'd1;
      if (wr_hit   && (wr_cnt != '1)) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign rd_count = rd_cnt;
  assign wr_count = wr_cnt;
`else
  logic unused_stats;
  assign unused_stats = rd_enter;
  assign rd_count     = '0;
  assign wr_count     = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances share one control interface, one
// with READ_LATENCY=1 and one with READ_LATENCY=4, each on its own data bus.
// Both buses carry a pulldown, so a lane nobody drives reads back as 0.
module tb_sram_responder;

`ifdef SRAM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_responder_if ifc ();

  logic        drv;
  logic [15:0] wdata;
  wire  [15:0] data1;
  wire  [15:0] data4;

  assign data1 = drv ? wdata : 16'bz;
  assign data4 = drv ? wdata : 16'bz;
  pulldown (data1);
  pulldown (data4);

  logic        valid1, valid4;
  logic [15:0] rdc1, wrc1, rdc4, wrc4;

  sram_responder #(.DEPTH_LOG2(10), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ctrl(ifc.slave), .SRAM_DATA(data1),
    .rdata_valid(valid1), .rd_count(rdc1), .wr_count(wrc1)
  );

  sram_responder #(.DEPTH_LOG2(10), .READ_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .ctrl(ifc.slave), .SRAM_DATA(data4),
    .rdata_valid(valid4), .rd_count(rdc4), .wr_count(wrc4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic ce, input logic we, input logic oe,
                         input logic ub, input logic lb, input logic [17:0] a,
                         input logic d, input logic [15:0] w);
    ifc.SRAM_CE_N    = ce;
    ifc.SRAM_WE_N    = we;
    ifc.SRAM_OE_N    = oe;
    ifc.SRAM_UB_N    = ub;
    ifc.SRAM_LB_N    = lb;
    ifc.SRAM_ADDRESS = a;
    drv              = d;
    wdata            = w;
  endtask

  task automatic idle();
    set_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0);
  endtask

  task automatic rd(input logic [17:0] a);
    set_bus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b0, 16'h0);
  endtask

  task automatic wr(input logic [17:0] a, input logic ub, input logic lb, input logic [15:0] w);
    set_bus(1'b0, 1'b0, 1'b1, ub, lb, a, 1'b1, w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        ce, we, oe, ub, lb;
    logic [17:0] addr;
    logic        d;
    logic [15:0] w;
    logic [15:0] exp_data;   // value seen on the L=1 bus after the edge
    logic        exp_valid;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Writes show the bench's own drive on the bus; undriven lanes read 0.
    vecs[0]  = '{"wr A5C3@5",      0,0,1,0,0, 18'h00005, 1, 16'hA5C3, 16'hA5C3, 0};
    vecs[1]  = '{"rd 5",           0,1,0,0,0, 18'h00005, 0, 16'h0000, 16'hA5C3, 1};
    vecs[2]  = '{"rd 5 hold",      0,1,0,0,0, 18'h00005, 0, 16'h0000, 16'hA5C3, 1};
    vecs[3]  = '{"idle",           1,1,1,1,1, 18'h00000, 0, 16'h0000, 16'h0000, 0};
    vecs[4]  = '{"wr 1234@9",      0,0,1,0,0, 18'h00009, 1, 16'h1234, 16'h1234, 0};
    vecs[5]  = '{"wr FF00@9 ub",   0,0,1,0,1, 18'h00009, 1, 16'hFF00, 16'hFF00, 0};
    vecs[6]  = '{"rd 9",           0,1,0,0,0, 18'h00009, 0, 16'h0000, 16'hFF34, 1};
    vecs[7]  = '{"rd 9 lb off",    0,1,0,0,1, 18'h00009, 0, 16'h0000, 16'hFF00, 1};
    vecs[8]  = '{"wr BEEF@403",    0,0,1,0,0, 18'h00403, 1, 16'hBEEF, 16'hBEEF, 0};
    vecs[9]  = '{"rd 3 alias",     0,1,0,0,0, 18'h00003, 0, 16'h0000, 16'hBEEF, 1};
    vecs[10] = '{"rd 5 addr chg",  0,1,0,0,0, 18'h00005, 0, 16'h0000, 16'hA5C3, 1};
    vecs[11] = '{"wr no lanes@5",  0,0,1,1,1, 18'h00005, 1, 16'h0000, 16'h0000, 0};
    vecs[12] = '{"rd 5 unchanged", 0,1,0,0,0, 18'h00005, 0, 16'h0000, 16'hA5C3, 1};
    vecs[13] = '{"idle end",       1,1,1,1,1, 18'h00000, 0, 16'h0000, 16'h0000, 0};

    idle();
    #12;
    check("reset valid1", {15'b0, valid1}, 16'h0);
    check("reset valid4", {15'b0, valid4}, 16'h0);
    check("reset bus1", data1, 16'h0000);
    check("reset rd_count", rdc1, 16'h0);
    check("reset wr_count", wrc1, 16'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int unsigned i = 0; i < 14; i++) begin
      set_bus(vecs[i].ce, vecs[i].we, vecs[i].oe, vecs[i].ub, vecs[i].lb,
              vecs[i].addr, vecs[i].d, vecs[i].w);
      tick();
      check({vecs[i].name, " data"}, data1, vecs[i].exp_data);
      check({vecs[i].name, " valid"}, {15'b0, valid1}, {15'b0, vecs[i].exp_valid});
    end
    // L=1: five reads reached data drive; L=4: every read was cut short.
    check("table rd_count L1", rdc1, STATS ? 16'd5 : 16'd0);
    check("table wr_count L1", wrc1, STATS ? 16'd5 : 16'd0);
    check("table rd_count L4", rdc4, 16'd0);
    check("table wr_count L4", wrc4, STATS ? 16'd5 : 16'd0);

    // Latency 4: bus quiet for three edges, data after the fourth.
    rd(18'h5);
    for (int unsigned e = 1; e <= 3; e++) begin
      tick();
      check("L4 wait valid", {15'b0, valid4}, 16'h0);
      check("L4 wait bus", data4, 16'h0000);
    end
    tick();
    check("L4 data", data4, 16'hA5C3);
    check("L4 valid", {15'b0, valid4}, 16'h1);
    check("L4 rd_count", rdc4, STATS ? 16'd1 : 16'd0);
    idle();
    tick();
    // Repeat with CE_N dropped on edge 2: no drive, no count.
    rd(18'h5);
    tick();
    idle();
    tick();
    for (int unsigned e = 0; e < 4; e++) begin
      tick();
      check("L4 abort valid", {15'b0, valid4}, 16'h0);
    end
    check("L4 abort rd_count", rdc4, STATS ? 16'd1 : 16'd0);

    // Write during RD_DRIVE releases the bus before the edge, then IDLE.
    rd(18'h5);
    tick();
    check("pre-write valid", {15'b0, valid1}, 16'h1);
    wr(18'h5, 1'b1, 1'b1, 16'h5A5A);
    #1;
    check("write release valid", {15'b0, valid1}, 16'h0);
    check("write release bus", data1, 16'h5A5A);
    tick();
    rd(18'h5);
    #1;
    check("after write idle", {15'b0, valid1}, 16'h0);
    tick();
    check("reread 5", data1, 16'hA5C3);
    check("reread 5 valid", {15'b0, valid1}, 16'h1);

    // Asynchronous reset while L=4 sits in RD_WAIT and L=1 is driving.
    idle();
    tick();
    rd(18'h9);
    tick();
    tick();
    check("pre-reset bus1", data1, 16'hFF34);
    #2;
    rst = 1'b0;
    #1;
    check("async rst valid1", {15'b0, valid1}, 16'h0);
    check("async rst valid4", {15'b0, valid4}, 16'h0);
    check("async rst bus1", data1, 16'h0000);
    check("async rst rd_count", rdc1, 16'h0);
    check("async rst wr_count", wrc1, 16'h0);
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Storage survives reset; counters restart: three reads, two writes.
    rd(18'h9);
    tick();
    check("post-rst rd 9", data1, 16'hFF34);
    check("post-rst valid", {15'b0, valid1}, 16'h1);
    idle();
    tick();
    rd(18'h3);
    tick();
    check("post-rst rd 3", data1, 16'hBEEF);
    idle();
    tick();
    rd(18'h5);
    tick();
    check("post-rst rd 5", data1, 16'hA5C3);
    idle();
    tick();
    wr(18'h3, 1'b1, 1'b1, 16'h0000);
    tick();
    tick();
    idle();
    tick();
    check("stats rd_count L1", rdc1, STATS ? 16'd3 : 16'd0);
    check("stats wr_count L1", wrc1, STATS ? 16'd2 : 16'd0);
    check("stats rd_count L4", rdc4, 16'd0);
    check("stats wr_count L4", wrc4, STATS ? 16'd2 : 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
